// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcode encodings,
// controller FSM state type and the default datapath width.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_INC    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 3-bit-opcode ALU; every result wraps modulo 2^DATA_W.
module ALU
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [2:0]        Op_code,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Y
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  always_comb begin
    Y = '0;
    case (Op_code)
      OP_PASS_A: Y = A;
      OP_ADD:    Y = A + B;
      OP_SUB:    Y = A - B;
      OP_AND:    Y = A & B;
      OP_OR:     Y = A | B;
      OP_INC:    Y = A + ONE;
      OP_DEC:    Y = A - ONE;
      OP_PASS_B: Y = B;
      default:   Y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... (mod NUM_REQ)
// for the first active request. grant is one-hot and gated by en.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (found && en) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU among NUM_REQ valid/ready requesters with round-robin
// arbitration; one op in flight, registered response tagged with requester id.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = ALU_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*3-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                window;
  logic                hs;
  int                  sel;

  logic [2:0]          op_p0;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic [ID_W-1:0]     id_p0;
  logic [DATA_W-1:0]   alu_y;

  // Reset is folded in so no requester sees ready while the block is held in reset.
  assign window    = rst_n & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));
  assign req_ready = grant;
  assign hs        = |grant;
  assign sel       = int'(grant_idx);
  assign busy      = (state != ST_IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (window),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  ALU #(.DATA_W(DATA_W)) u_alu (
    .Op_code (op_p0),
    .A       (a_p0),
    .B       (b_p0),
    .Y       (alu_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = hs ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (hs) rr_ptr <= grant_idx;
    end
  end

  // p0: operands captured on the request handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      id_p0 <= '0;
    end else if (hs) begin
      op_p0 <= req_op[sel*3 +: 3];
      a_p0  <= req_a[sel*DATA_W +: DATA_W];
      b_p0  <= req_b[sel*DATA_W +: DATA_W];
      id_p0 <= grant_idx;
    end
  end

  // response register: loaded from the ALU in EXEC, held until rsp_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (state == ST_EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_id    <= id_p0;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
